// File: rtl/cache_sys_pkg.sv
// Shared geometry, derived address-field widths and FSM state encoding for cache_sys.
package cache_sys_pkg;

    localparam int unsigned LINES       = 8;
    localparam int unsigned BLOCK_BYTES = 16;
    localparam int unsigned BLOCK_BITS  = BLOCK_BYTES * 8;
    localparam int unsigned OFFSET_W    = $clog2(BLOCK_BYTES);
    localparam int unsigned INDEX_W     = $clog2(LINES);

    typedef enum logic [2:0] {
        StIdle,
        StLookup,
        StFill,
        StMemWr,
        StResp,
        StRelease
    } state_e;

endpackage

// File: rtl/cache_sys_mem.sv
// Byte-array main memory: combinational whole-block read port, clocked word write port.
module cache_sys_mem
    import cache_sys_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 1024,
    parameter int unsigned ADDR_W    = $clog2(MEM_BYTES)
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [ADDR_W-3:0]          wword,
    input  logic [31:0]                wdata,
    input  logic [ADDR_W-OFFSET_W-1:0] rblock,
    output logic [BLOCK_BITS-1:0]      rdata
);

    // Deliberately no reset: memory contents survive a subsystem reset.
    logic [7:0] mem_q [MEM_BYTES];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                mem_q[{wword, 2'(i)}] <= wdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        rdata = '0;
        for (int i = 0; i < int'(BLOCK_BYTES); i++) begin
            rdata[8*i +: 8] = mem_q[{rblock, OFFSET_W'(i)}];
        end
    end

endmodule

// File: rtl/cache_sys.sv
// Direct-mapped write-through, no-write-allocate cache in front of an embedded byte memory.
module cache_sys
    import cache_sys_pkg::*;
#(
    parameter int unsigned MEM_BYTES   = 1024,
    parameter int unsigned MEM_LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_read,
    input  logic        cpu_write,
    input  logic [31:0] cpu_address,
    input  logic [31:0] cpu_wdata,
    output logic [7:0]  cpu_data_out,
    output logic        ready
);

    localparam int unsigned ADDR_W = $clog2(MEM_BYTES);
    localparam int unsigned TAG_W  = ADDR_W - OFFSET_W - INDEX_W;
    localparam int unsigned CNT_W  = $clog2(MEM_LATENCY + 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         wdata_q;
    logic                is_write_q;
    logic                hit_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [LINES-1:0]    valid_q;
    logic [TAG_W-1:0]    tag_q  [LINES];
    logic [BLOCK_BITS-1:0] line_q [LINES];

    logic [OFFSET_W-1:0] off;
    logic [INDEX_W-1:0]  idx;
    logic [TAG_W-1:0]    tag;
    logic                hit, mem_done, mem_we, fill_done;
    logic [BLOCK_BITS-1:0] mem_rdata;
    logic                unused_addr;

    assign unused_addr = ^cpu_address[31:ADDR_W];
    assign off         = addr_q[OFFSET_W-1:0];
    assign idx         = addr_q[OFFSET_W +: INDEX_W];
    assign tag         = addr_q[ADDR_W-1 -: TAG_W];
    assign hit         = valid_q[idx] && (tag_q[idx] == tag);
    assign mem_done    = (cnt_q == CNT_W'(MEM_LATENCY - 1));

    cache_sys_mem #(
        .MEM_BYTES (MEM_BYTES),
        .ADDR_W    (ADDR_W)
    ) u_mem (
        .clk    (clk),
        .we     (mem_we),
        .wword  (addr_q[ADDR_W-1:2]),
        .wdata  (wdata_q),
        .rblock (addr_q[ADDR_W-1:OFFSET_W]),
        .rdata  (mem_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (cpu_read || cpu_write) state_d = StLookup;
            StLookup:  state_d = is_write_q ? StMemWr : (hit ? StResp : StFill);
            StFill,
            StMemWr:   if (mem_done) state_d = StResp;
            StResp:    state_d = StRelease;
            StRelease: if (!cpu_read && !cpu_write) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        ready     = (state_q == StResp);
        mem_we    = (state_q == StMemWr) && mem_done;
        fill_done = (state_q == StFill) && mem_done;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q       <= '0;
            wdata_q      <= '0;
            is_write_q   <= 1'b0;
            hit_q        <= 1'b0;
            cnt_q        <= '0;
            valid_q      <= '0;
            cpu_data_out <= 8'h00;
        end else begin
            cnt_q <= (state_q == StFill || state_q == StMemWr) ? cnt_q + 1'b1 : '0;
            if (state_q == StIdle && (cpu_read || cpu_write)) begin
                addr_q     <= cpu_address[ADDR_W-1:0];
                wdata_q    <= cpu_wdata;
                is_write_q <= cpu_write;
            end
            if (state_q == StLookup) begin
                hit_q <= hit;
                if (!is_write_q && hit) cpu_data_out <= line_q[idx][{off, 3'b000} +: 8];
            end
            if (fill_done) begin
                valid_q[idx] <= 1'b1;
                cpu_data_out <= mem_rdata[{off, 3'b000} +: 8];
            end
        end
    end

    // Line payload and tags are only meaningful under valid_q, so they carry no reset.
    always_ff @(posedge clk) begin
        if (fill_done) begin
            line_q[idx] <= mem_rdata;
            tag_q[idx]  <= tag;
        end
        if (mem_we && hit_q) begin
            line_q[idx][{off[OFFSET_W-1:2], 5'b00000} +: 32] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_cache_sys.sv
// Self-checking bench for cache_sys: scoreboarded read data, latency and ready-pulse checks.
module tb_cache_sys;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_read;
    logic        cpu_write;
    logic [31:0] cpu_address;
    logic [31:0] cpu_wdata;
    logic [7:0]  cpu_data_out;
    logic        ready;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    logic [7:0] exp_q[$];

    localparam int HIT_LAT  = 2;
    localparam int MISS_LAT = 2 + 4;

    cache_sys #(
        .MEM_BYTES   (1024),
        .MEM_LATENCY (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_read     (cpu_read),
        .cpu_write    (cpu_write),
        .cpu_address  (cpu_address),
        .cpu_wdata    (cpu_wdata),
        .cpu_data_out (cpu_data_out),
        .ready        (ready)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (ready === 1'b1) pulses++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One handshake; read data is scoreboarded at drive time and popped at ready.
    task automatic run_op(input string name, input logic wr, input logic rd,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [7:0] exp_byte, input int exp_lat);
        int cyc = 0;
        int p0;
        logic [7:0] e;
        if (!wr) exp_q.push_back(exp_byte);
        p0 = pulses;
        cpu_address = addr;
        cpu_wdata   = wdata;
        cpu_write   = wr;
        cpu_read    = rd;
        while (cyc < 50) begin
            @(posedge clk);
            cyc++;
            #1;
            if (ready === 1'b1) break;
        end
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_timeout: got %b want 1", name, ready);
            if (!wr) e = exp_q.pop_front();
        end else begin
            checks++;
            if (cyc !== exp_lat) begin
                errors++;
                $display("FAIL %s latency: got %0d want %0d", name, cyc, exp_lat);
            end
            if (!wr) begin
                e = exp_q.pop_front();
                checks++;
                if (cpu_data_out !== e) begin
                    errors++;
                    $display("FAIL %s data: got %h want %h", name, cpu_data_out, e);
                end
            end
        end
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (pulses - p0 !== 1) begin
            errors++;
            $display("FAIL %s pulse_count: got %0d want 1", name, pulses - p0);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        cpu_read = 1'b0;
        cpu_write = 1'b0;
        cpu_address = '0;
        cpu_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (ready !== 1'b0 || cpu_data_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: got ready=%b data=%h want 0/00", ready, cpu_data_out);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_write_read();
        logic [31:0] addrs [6] = '{32'h20, 32'h40, 32'h60, 32'h80, 32'hA0, 32'hC0};
        logic [31:0] words [6] = '{32'hAAAAAAAA, 32'h55555555, 32'hCAFEC0FF,
                                   32'h12345678, 32'hBEEF0001, 32'h00000000};
        logic [7:0]  bytes [6] = '{8'hAA, 8'h55, 8'hFF, 8'h78, 8'h01, 8'h00};
        for (int i = 0; i < 6; i++) run_op("write", 1'b1, 1'b0, addrs[i], words[i], 8'h00, MISS_LAT);
        for (int i = 0; i < 6; i++) run_op("read_miss", 1'b0, 1'b1, addrs[i], '0, bytes[i], MISS_LAT);
    endtask

    task automatic test_hit();
        run_op("hit_63", 1'b0, 1'b1, 32'h63, '0, 8'hCA, HIT_LAT);
        run_op("hit_61", 1'b0, 1'b1, 32'h61, '0, 8'hC0, HIT_LAT);
    endtask

    task automatic test_conflict();
        run_op("conflict_20", 1'b0, 1'b1, 32'h20, '0, 8'hAA, MISS_LAT);
        run_op("conflict_A0", 1'b0, 1'b1, 32'hA0, '0, 8'h01, MISS_LAT);
        run_op("conflict_20b", 1'b0, 1'b1, 32'h20, '0, 8'hAA, MISS_LAT);
    endtask

    task automatic test_write_hit();
        run_op("wh_fill", 1'b0, 1'b1, 32'h40, '0, 8'h55, MISS_LAT);
        run_op("wh_write", 1'b1, 1'b0, 32'h40, 32'h11223344, 8'h00, MISS_LAT);
        run_op("wh_read", 1'b0, 1'b1, 32'h40, '0, 8'h44, HIT_LAT);
        run_op("wh_read43", 1'b0, 1'b1, 32'h43, '0, 8'h11, HIT_LAT);
    endtask

    task automatic test_hold();
        int cyc = 0;
        int p0 = pulses;
        cpu_address = 32'h44;
        cpu_wdata   = 32'hDEADBEEF;
        cpu_write   = 1'b1;
        while (cyc < 50 && ready !== 1'b1) begin
            @(posedge clk);
            cyc++;
            #1;
        end
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL hold_ready: got %b want 1", ready);
        end
        // A re-executed write would store this altered word.
        cpu_wdata = 32'h0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_no_repeat: got ready=%b want 0 (cycle %0d)", ready, i);
            end
        end
        cpu_write = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (pulses - p0 !== 1) begin
            errors++;
            $display("FAIL hold_pulses: got %0d want 1", pulses - p0);
        end
        run_op("hold_read44", 1'b0, 1'b1, 32'h44, '0, 8'hEF, HIT_LAT);
        run_op("hold_read47", 1'b0, 1'b1, 32'h47, '0, 8'hDE, HIT_LAT);
    endtask

    task automatic test_both();
        run_op("both_req", 1'b1, 1'b1, 32'h100, 32'h9ABCDEF0, 8'h00, MISS_LAT);
        run_op("both_read", 1'b0, 1'b1, 32'h100, '0, 8'hF0, MISS_LAT);
        run_op("both_read2", 1'b0, 1'b1, 32'h102, '0, 8'hBC, HIT_LAT);
    endtask

    task automatic test_reset_fill();
        cpu_address = 32'hA0;
        cpu_read    = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst      = 1'b0;
        cpu_read = 1'b0;
        #1;
        checks++;
        if (ready !== 1'b0 || cpu_data_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_fill_outputs: got ready=%b data=%h want 0/00", ready, cpu_data_out);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (ready !== 1'b0) begin
                errors++;
                $display("FAIL reset_fill_no_ready: got %b want 0 (cycle %0d)", ready, i);
            end
        end
        run_op("after_reset_A0", 1'b0, 1'b1, 32'hA0, '0, 8'h01, MISS_LAT);
        run_op("after_reset_60", 1'b0, 1'b1, 32'h60, '0, 8'hFF, MISS_LAT);
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_hit();
        test_conflict();
        test_write_hit();
        test_hold();
        test_both();
        test_reset_fill();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
